// File: rtl/timer_slot_arbiter.sv
// timer_slot_arbiter: shares one CW-bit up-counter among NREQ requesters.
// Round-robin grant, latch the winner's interval, count 0..limit, pulse done.
module timer_slot_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   len,
    output logic [NREQ-1:0]      gnt,
    output logic [CW-1:0]        cnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [CW-1:0]   limit, limit_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic [NREQ-1:0] gnt_nxt, done_nxt;
    logic            busy_nxt;

    logic            found;
    logic [PW-1:0]   win;
    int unsigned     idx;

    // Round-robin search: first requesting index starting at ptr+1, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        limit_nxt = limit;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                gnt_nxt  = '0;
                cnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (found) begin
                    state_nxt     = RUN;
                    owner_nxt     = win;
                    ptr_nxt       = win;
                    limit_nxt     = len[win*CW +: CW];
                    gnt_nxt[win]  = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            RUN: begin
                // Abort is checked first so it wins over completion in the same cycle
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else if (cnt == limit) begin
                    state_nxt       = DONE;
                    gnt_nxt         = '0;
                    done_nxt[owner] = 1'b1;
                    busy_nxt        = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= PW'(NREQ - 1);
            owner <= '0;
            limit <= '0;
            cnt   <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            limit <= limit_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_timer_slot_arbiter.sv
// Scoreboard bench for timer_slot_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_timer_slot_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*CW-1:0]   len = '0;
    logic [NREQ-1:0]      gnt;
    logic [CW-1:0]        cnt;
    logic [NREQ-1:0]      done;
    logic                 busy;

    timer_slot_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len  (len),
        .gnt  (gnt),
        .cnt  (cnt),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [CW-1:0]   cnt;
        logic [NREQ-1:0] done;
        logic            busy;
    } exp_t;

    exp_t expq[$];
    int   gnt_log[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: an interval in progress is (owner, elapsed, limit);
    // m_done_now marks the single completion cycle.
    int   m_owner;
    int   m_elapsed;
    int   m_lim;
    int   m_last;
    bit   m_done_now;
    exp_t last_exp;

    task automatic check(input string name, input exp_t act, input exp_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got gnt=%b cnt=%0d done=%b busy=%b, expected gnt=%b cnt=%0d done=%b busy=%b",
                     name, $time, act.gnt, act.cnt, act.done, act.busy,
                     exp.gnt, exp.cnt, exp.done, exp.busy);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner    = -1;
        m_elapsed  = 0;
        m_lim      = 0;
        m_last     = NREQ - 1;
        m_done_now = 1'b0;
    endfunction

    // Predicts the outputs after the next rising edge given the inputs seen there
    function automatic exp_t model_step(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
        exp_t e;
        int   w;
        e = '0;
        w = -1;
        if (m_done_now) begin
            m_done_now = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && r[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            if (w >= 0) begin
                m_owner   = w;
                m_last    = w;
                m_lim     = int'(l[w*CW +: CW]);
                m_elapsed = 0;
                e.gnt[w]  = 1'b1;
                e.busy    = 1'b1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_elapsed == m_lim) begin
            e.done[m_owner] = 1'b1;
            e.cnt           = CW'(m_lim);
            e.busy          = 1'b1;
            m_done_now      = 1'b1;
            m_owner         = -1;
        end else begin
            m_elapsed++;
            e.gnt[m_owner] = 1'b1;
            e.cnt          = CW'(m_elapsed);
            e.busy         = 1'b1;
        end
        return e;
    endfunction

    task automatic tick(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
        @(negedge clk);
        rst = 1'b1;
        req = r;
        len = l;
        last_exp = model_step(r, l);
        expq.push_back(last_exp);
    endtask

    // Monitor: after every rising edge, compare outputs with the oldest prediction
    initial begin
        logic [NREQ-1:0] pg;
        exp_t            e;
        pg = '0;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("cycle", {gnt, cnt, done, busy}, e);
            end
            if (gnt != '0 && pg == '0)
                for (int i = 0; i < NREQ; i++)
                    if (gnt[i]) gnt_log.push_back(i);
            pg = gnt;
        end
    end

    initial begin
        logic [NREQ*CW-1:0] lv;
        logic [NREQ-1:0]    r;
        int                 nl;

        model_reset();
        #2;
        check("reset_state", {gnt, cnt, done, busy}, '0);

        // Round robin, two rounds from the reset pointer
        for (int round = 0; round < 2; round++) begin
            lv = '0;
            for (int i = 0; i < NREQ; i++) lv[i*CW +: CW] = 8'd1;
            gnt_log.delete();
            r = '1;
            repeat (20) begin
                tick(r, lv);
                r = r & ~last_exp.done;
            end
            repeat (2) tick('0, lv);
            check_val("rr_count", gnt_log.size(), NREQ);
            for (int i = 0; i < NREQ && i < gnt_log.size(); i++)
                check_val("rr_order", gnt_log[i], i);
        end

        // Single request, len1=3
        lv = '0;
        lv[1*CW +: CW] = 8'd3;
        repeat (6) tick(4'b0010, lv);
        repeat (2) tick('0, lv);

        // Zero length
        lv = '0;
        repeat (3) tick(4'b0001, lv);
        repeat (2) tick('0, lv);

        // Abort at cnt=4, pending requester 3 granted one cycle later
        lv = '0;
        lv[2*CW +: CW] = 8'd10;
        lv[3*CW +: CW] = 8'd1;
        gnt_log.delete();
        repeat (5) tick(4'b0100, lv);
        repeat (4) tick(4'b1000, lv);
        repeat (2) tick('0, lv);
        check_val("abort_log_size", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check_val("abort_first", gnt_log[0], 2);
            check_val("abort_second", gnt_log[1], 3);
        end

        // Maximum length
        lv = '0;
        lv[0 +: CW] = 8'd255;
        repeat (257) tick(4'b0001, lv);
        repeat (2) tick('0, lv);

        // Reset in the middle of a run, then requester 0 wins first
        lv = '0;
        lv[0 +: CW] = 8'd20;
        repeat (8) tick(4'b0001, lv);
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        #1;
        check("async_reset", {gnt, cnt, done, busy}, '0);
        model_reset();
        gnt_log.delete();
        lv = '0;
        lv[0*CW +: CW] = 8'd2;
        lv[1*CW +: CW] = 8'd2;
        r = 4'b0011;
        repeat (14) begin
            tick(r, lv);
            r = r & ~last_exp.done;
        end
        repeat (2) tick('0, lv);
        check_val("post_reset_grants", gnt_log.size(), 2);
        if (gnt_log.size() > 0) check_val("post_reset_first", gnt_log[0], 0);

        // Random traffic: requests, aborts, releases after done, len changes during runs
        r = '0;
        repeat (3000) begin
            for (int i = 0; i < NREQ; i++) begin
                nl = ($urandom % 64 == 0) ? 255 : int'($urandom_range(0, 6));
                if (!r[i]) begin
                    if ($urandom % 4 == 0) begin
                        r[i] = 1'b1;
                        lv[i*CW +: CW] = CW'(nl);
                    end
                end else if (last_exp.done[i] && ($urandom % 2 == 0)) begin
                    r[i] = 1'b0;
                end else if ($urandom % 40 == 0) begin
                    r[i] = 1'b0;
                end else if ($urandom % 8 == 0) begin
                    lv[i*CW +: CW] = CW'(nl);
                end
            end
            tick(r, lv);
        end
        repeat (3) tick('0, lv);
        @(negedge clk);
        @(negedge clk);
        check_val("queue_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_slot_arbiter.md
# timer_slot_arbiter

- Shares one 8-bit up-counter between NREQ requesters, each of which needs a timed interval.
- Arbitrates round-robin, latches the winner's interval length and runs the counter from 0 to that length.
- Reports completion to the owner with a one-cycle done pulse, then returns the counter to the pool.
- Sits between the control logic that needs delays and the single shared counter resource.

## Interface
- NREQ, 4, number of requesters (2..8)
- CW, 8, counter/length width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request level; held high until done or to abort
- len  input  NREQ*CW  flattened interval lengths; requester i uses bits [i*CW +: CW]
- gnt  output  NREQ  one-hot grant; high for the whole RUN phase of the owner
- cnt  output  CW  shared counter value
- done  output  NREQ  one-cycle completion pulse to the owner
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE, no req: outputs hold gnt=0, done=0, cnt=0, busy=0.
- IDLE, any req bit high:
  - Pick the winner round-robin. Search starts at ptr+1 and wraps modulo NREQ.
  - Latch len[winner] into limit and winner into owner; set ptr=winner.
  - Next state RUN with gnt[winner]=1 and cnt=0.
- RUN, req[owner] high and cnt!=limit: cnt increments by 1.
- RUN, req[owner] high and cnt==limit: next state DONE. gnt=0, done[owner]=1, cnt holds limit.
- RUN, req[owner] low (abort): next state IDLE. gnt=0, cnt=0, no done pulse. ptr stays at owner.
  - Abort has priority over cnt==limit in the same cycle.
- DONE: lasts one cycle, then IDLE with done=0 and cnt=0.
- len changes during RUN are ignored; limit is latched at grant.
- Requests from non-owners during RUN/DONE are not sampled; they are arbitrated in the next IDLE.
- A requester still holding req after its done is eligible again, but only after higher-rotation requesters are served.
- Width rules: the counter never wraps; the maximum limit 2^CW-1 completes at cnt=2^CW-1. len=0 completes after one RUN cycle.
- Reset values: state IDLE, gnt=0, done=0, cnt=0, busy=0, ptr=NREQ-1 (so requester 0 wins first), limit=0, owner=0.
- Reset mid-operation: all of the above apply immediately (asynchronous), with no done pulse.

## Timing
- Grant latency: req sampled high at edge in IDLE (cycle t) gives gnt and busy high from t+1.
- RUN lasts limit+1 cycles; cnt reads 0,1,..,limit on cycles t+1..t+1+limit.
- done pulses on cycle t+2+limit, the same cycle gnt drops.
- The IDLE that follows DONE is one cycle minimum.
- Back-to-back grants: minimum spacing from one grant to the next is limit+3 cycles.
- Abort: req[owner] low at cycle a during RUN gives gnt=0, cnt=0, busy=0 at a+1. A new grant is possible at a+2.

## Test plan
- Single request: req=0010 with len1=3 at cycle 0 → gnt=0010 on cycles 1-4, cnt=0,1,2,3, done=0010 on cycle 5, busy=0 on cycle 6.
- Zero length: req=0001 with len0=0 → gnt for exactly 1 cycle with cnt=0, then done=0001 on the next cycle.
- Round-robin: req=1111 held, all len=1, release each req after its done → grant order 0,1,2,3. Re-assert all → order 0,1,2,3 again.
- Abort: req=0100 with len2=10, drop req2 when cnt=4 → next cycle gnt=0, cnt=0, no done. A pending req=1000 is granted one cycle later.
- Max length: len=255 → cnt reaches 255 without wrap; done follows 256 RUN cycles after grant.
- Reset mid-run: assert rst low while cnt=7 → gnt, done, cnt and busy go to 0 asynchronously. After release, req=0001 and 0010 together grant requester 0 first.
